iob_regfile_wstrb_nr: RTL and testbench

- Single-clock register file: 2**ADDR_W entries of DATA_W bits.
- One write port with per-byte strobes, a synchronous bulk clear, and N_RD independent registered read ports.
- Each read port has optional write-to-read bypass and a read-valid flag.
- Next generation of the iob regfile family, used for CSR banks and small multi-reader lookup stores inside one clock domain.

---
 rtl/iob_regfile_wstrb_nr_pkg.sv | 11 +
 rtl/iob_regfile_wstrb_nr_if.sv | 32 +++
 rtl/iob_regfile_wstrb_nr_rport.sv | 52 +++++
 rtl/iob_regfile_wstrb_nr.sv | 98 +++++++++
 tb/tb_iob_regfile_wstrb_nr.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/iob_regfile_wstrb_nr_pkg.sv
// Shared constants and helpers for the strobed multi-read-port register file.
package iob_regfile_wstrb_nr_pkg;

  localparam int unsigned BYTE_W = 8;

  // Number of byte lanes (write strobes) covering a DATA_W-bit entry.
  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/iob_regfile_wstrb_nr_if.sv
// Write/clear/read bus of the register file; master drives requests, slave returns read data.
interface iob_regfile_wstrb_nr_if
  import iob_regfile_wstrb_nr_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_RD   = 2
);

  localparam int unsigned STRB_W = strb_w(DATA_W);

  logic                     clear_i;
  logic                     w_en_i;
  logic [STRB_W-1:0]        w_strb_i;
  logic [ADDR_W-1:0]        w_addr_i;
  logic [DATA_W-1:0]        w_data_i;
  logic [N_RD-1:0]          r_en_i;
  logic [N_RD*ADDR_W-1:0]   r_addr_i;
  logic [N_RD*DATA_W-1:0]   r_data_o;
  logic [N_RD-1:0]          r_valid_o;

  modport master (
    output clear_i, w_en_i, w_strb_i, w_addr_i, w_data_i, r_en_i, r_addr_i,
    input  r_data_o, r_valid_o
  );

  modport slave (
    input  clear_i, w_en_i, w_strb_i, w_addr_i, w_data_i, r_en_i, r_addr_i,
    output r_data_o, r_valid_o
  );

endinterface

// File: rtl/iob_regfile_wstrb_nr_rport.sv
// One registered read port: address mux, optional write/clear bypass, data register and valid flag.
module iob_regfile_wstrb_nr_rport #(
  parameter int unsigned          ADDR_W  = 3,
  parameter int unsigned          DATA_W  = 32,
  parameter bit                   BYPASS  = 1'b1,
  parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic [DATA_W-1:0]   mem_i [1<<ADDR_W],
  input  logic                clear_i,
  input  logic                w_en_i,
  input  logic [ADDR_W-1:0]   w_addr_i,
  input  logic [DATA_W-1:0]   w_merged_i,
  input  logic                r_en_i,
  input  logic [ADDR_W-1:0]   r_addr_i,
  output logic [DATA_W-1:0]   r_data_o,
  output logic                r_valid_o
);

  logic [DATA_W-1:0] rd_sel;
  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;

  // With bypass the port sees the post-edge entry value, so clear and write are forwarded.
  always_comb begin
    rd_sel = mem_i[r_addr_i];
    if (BYPASS) begin
      if (clear_i) begin
        rd_sel = RST_VAL;
      end else if (w_en_i && (w_addr_i == r_addr_i)) begin
        rd_sel = w_merged_i;
      end
    end
    data_d  = r_en_i ? rd_sel : data_q;
    valid_d = r_en_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign r_data_o  = data_q;
  assign r_valid_o = valid_q;

endmodule

// File: rtl/iob_regfile_wstrb_nr.sv
// Register file with byte-strobed write, synchronous bulk clear and N_RD registered read ports.
module iob_regfile_wstrb_nr
  import iob_regfile_wstrb_nr_pkg::*;
#(
  parameter int unsigned          ADDR_W  = 3,
  parameter int unsigned          DATA_W  = 32,
  parameter int unsigned          N_RD    = 2,
  parameter bit                   BYPASS  = 1'b1,
  parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  iob_regfile_wstrb_nr_if.slave   bus
);

  localparam int unsigned STRB_W = strb_w(DATA_W);
  localparam int unsigned N_ENT  = 1 << ADDR_W;

  if ((DATA_W % BYTE_W) != 0 || DATA_W < BYTE_W) begin : g_chk_data_w
    $error("iob_regfile_wstrb_nr: DATA_W must be a non-zero multiple of 8");
  end
  if (N_RD < 1 || N_RD > 8) begin : g_chk_n_rd
    $error("iob_regfile_wstrb_nr: N_RD must be in 1..8");
  end
  if (ADDR_W < 1 || ADDR_W > 8) begin : g_chk_addr_w
    $error("iob_regfile_wstrb_nr: ADDR_W must be in 1..8");
  end

  logic [DATA_W-1:0] mem_q [N_ENT];
  logic [DATA_W-1:0] mem_d [N_ENT];
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] rd_data  [N_RD];
  logic [N_RD-1:0]   rd_valid;

  // Strobe merge: new bytes where strobed, current entry bytes elsewhere.
  always_comb begin
    w_merged = mem_q[bus.w_addr_i];
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (bus.w_strb_i[b]) begin
        w_merged[b*BYTE_W +: BYTE_W] = bus.w_data_i[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    for (int unsigned e = 0; e < N_ENT; e++) begin
      if (bus.clear_i) begin
        mem_d[e] = RST_VAL;
      end else if (bus.w_en_i && (bus.w_addr_i == ADDR_W'(e))) begin
        mem_d[e] = w_merged;
      end else begin
        mem_d[e] = mem_q[e];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int unsigned e = 0; e < N_ENT; e++) begin
        mem_q[e] <= RST_VAL;
      end
    end else begin
      for (int unsigned e = 0; e < N_ENT; e++) begin
        mem_q[e] <= mem_d[e];
      end
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rport
    iob_regfile_wstrb_nr_rport #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .BYPASS  (BYPASS),
      .RST_VAL (RST_VAL)
    ) u_rport (
      .clk_i      (clk_i),
      .arst_n_i   (arst_n_i),
      .mem_i      (mem_q),
      .clear_i    (bus.clear_i),
      .w_en_i     (bus.w_en_i),
      .w_addr_i   (bus.w_addr_i),
      .w_merged_i (w_merged),
      .r_en_i     (bus.r_en_i[k]),
      .r_addr_i   (bus.r_addr_i[k*ADDR_W +: ADDR_W]),
      .r_data_o   (rd_data[k]),
      .r_valid_o  (rd_valid[k])
    );
  end

  always_comb begin
    bus.r_data_o  = '0;
    for (int unsigned k = 0; k < N_RD; k++) begin
      bus.r_data_o[k*DATA_W +: DATA_W] = rd_data[k];
    end
    bus.r_valid_o = rd_valid;
  end

endmodule

// File: tb/tb_iob_regfile_wstrb_nr.sv
// Randomized and directed bench for iob_regfile_wstrb_nr; BYPASS=1 and BYPASS=0 instances share stimulus.
module tb_iob_regfile_wstrb_nr;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_RD   = 2;
  localparam int unsigned N_ENT  = 8;
  localparam int unsigned STRB_W = 4;
  localparam logic [DATA_W-1:0] RST_VAL = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic                   clear, w_en;
  logic [STRB_W-1:0]      strb;
  logic [ADDR_W-1:0]      waddr;
  logic [DATA_W-1:0]      wdata;
  logic [N_RD-1:0]        r_en;
  logic [N_RD*ADDR_W-1:0] raddr;

  iob_regfile_wstrb_nr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RD(N_RD)) bus_b ();
  iob_regfile_wstrb_nr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RD(N_RD)) bus_n ();

  assign bus_b.clear_i = clear;  assign bus_n.clear_i = clear;
  assign bus_b.w_en_i = w_en;    assign bus_n.w_en_i = w_en;
  assign bus_b.w_strb_i = strb;  assign bus_n.w_strb_i = strb;
  assign bus_b.w_addr_i = waddr; assign bus_n.w_addr_i = waddr;
  assign bus_b.w_data_i = wdata; assign bus_n.w_data_i = wdata;
  assign bus_b.r_en_i = r_en;    assign bus_n.r_en_i = r_en;
  assign bus_b.r_addr_i = raddr; assign bus_n.r_addr_i = raddr;

  iob_regfile_wstrb_nr #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RD(N_RD), .BYPASS(1'b1), .RST_VAL(RST_VAL)
  ) dut_b (.clk_i(clk), .arst_n_i(arst_n), .bus(bus_b));

  iob_regfile_wstrb_nr #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RD(N_RD), .BYPASS(1'b0), .RST_VAL(RST_VAL)
  ) dut_n (.clk_i(clk), .arst_n_i(arst_n), .bus(bus_n));

  // Reference model: entry array plus expected output registers per instance.
  logic [DATA_W-1:0] mem   [N_ENT];
  logic [DATA_W-1:0] exp_b [N_RD];
  logic [DATA_W-1:0] exp_n [N_RD];
  logic [N_RD-1:0]   exp_v;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int unsigned k = 0; k < N_RD; k++) begin
      check($sformatf("%s byp data%0d", tag, k), bus_b.r_data_o[k*DATA_W +: DATA_W], exp_b[k]);
      check($sformatf("%s nob data%0d", tag, k), bus_n.r_data_o[k*DATA_W +: DATA_W], exp_n[k]);
      check($sformatf("%s byp valid%0d", tag, k), 32'(bus_b.r_valid_o[k]), 32'(exp_v[k]));
      check($sformatf("%s nob valid%0d", tag, k), 32'(bus_n.r_valid_o[k]), 32'(exp_v[k]));
    end
  endtask

  task automatic model_reset();
    for (int unsigned e = 0; e < N_ENT; e++) mem[e] = RST_VAL;
    for (int unsigned k = 0; k < N_RD; k++) begin
      exp_b[k] = '0;
      exp_n[k] = '0;
    end
    exp_v = '0;
  endtask

  // One clock: predict from the current inputs, take the edge, then compare.
  task automatic tick(input string tag);
    logic [DATA_W-1:0] nm [N_ENT];
    logic [ADDR_W-1:0] a;
    for (int unsigned e = 0; e < N_ENT; e++) nm[e] = clear ? RST_VAL : mem[e];
    if (!clear && w_en) begin
      for (int unsigned b = 0; b < STRB_W; b++)
        if (strb[b]) nm[waddr][b*8 +: 8] = wdata[b*8 +: 8];
    end
    for (int unsigned k = 0; k < N_RD; k++) begin
      a = raddr[k*ADDR_W +: ADDR_W];
      if (r_en[k]) begin
        exp_b[k] = nm[a];
        exp_n[k] = mem[a];
      end
      exp_v[k] = r_en[k];
    end
    @(posedge clk);
    #1;
    for (int unsigned e = 0; e < N_ENT; e++) mem[e] = nm[e];
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    clear = 1'b0; w_en = 1'b0; strb = '0; waddr = '0; wdata = '0; r_en = '0; raddr = '0;
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    w_en = 1'b1; waddr = a; wdata = d; strb = s;
  endtask

  // Reset pulse placed between edges while the previous inputs stay applied.
  task automatic mid_reset();
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    #1 arst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    arst_n = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    arst_n = 1'b1;

    for (int unsigned a = 0; a < N_ENT; a++) begin
      r_en = 2'b01; raddr = {3'd0, 3'(a)};
      tick("rst_read");
      check("rst_val", bus_b.r_data_o[31:0], RST_VAL);
    end
    r_en = '0;
    tick("rd_idle");

    write(3'd3, 32'h1122_3344, 4'hF);          tick("wr_full");
    write(3'd3, 32'hFFFF_FFFF, 4'b0101);       tick("wr_strb");
    w_en = 1'b0; r_en = 2'b01; raddr = {3'd0, 3'd3};
    tick("rd_strb");
    check("strb_merge", bus_b.r_data_o[31:0], 32'h11FF_33FF);

    r_en = '0;
    write(3'd5, 32'h0, 4'hF);                  tick("wr_zero");
    write(3'd5, 32'hDEAD_BEEF, 4'b1100);
    r_en = 2'b10; raddr = {3'd5, 3'd0};
    tick("bypass");
    check("bypass_on", bus_b.r_data_o[63:32], 32'hDEAD_0000);
    check("bypass_off", bus_n.r_data_o[63:32], 32'h0000_0000);

    r_en = '0;
    for (int unsigned a = 0; a < N_ENT; a++) begin
      write(3'(a), 32'h0101_0101 * (a + 1), 4'hF);
      tick("fill");
    end
    clear = 1'b1; write(3'd2, 32'h1234_5678, 4'hF);
    r_en = 2'b01; raddr = {3'd0, 3'd2};
    tick("clr_wr");
    check("clear_prio", bus_b.r_data_o[31:0], RST_VAL);
    check("clear_old", bus_n.r_data_o[31:0], 32'h0303_0303);
    clear = 1'b0; w_en = 1'b0;
    for (int unsigned a = 0; a < N_ENT; a++) begin
      r_en = 2'b11; raddr = {3'(N_ENT - 1 - a), 3'(a)};
      tick("post_clr");
    end

    r_en = '0;
    write(3'd1, 32'hCAFE_0001, 4'hF); tick("wr1");
    write(3'd6, 32'hBEEF_0006, 4'hF); tick("wr6");
    w_en = 1'b0;
    r_en = 2'b11; raddr = {3'd6, 3'd1};
    for (int unsigned i = 0; i < 4; i++) tick("multi");
    r_en = 2'b01;
    tick("hold");
    check("hold_data", bus_b.r_data_o[63:32], 32'hBEEF_0006);
    check("hold_valid", 32'(bus_b.r_valid_o[1]), 32'd0);
    tick("hold2");

    for (int unsigned i = 0; i < 400; i++) begin
      clear = ($urandom_range(31) == 0);
      w_en  = $urandom_range(1) == 1;
      strb  = 4'($urandom_range(15));
      waddr = 3'($urandom_range(N_ENT - 1));
      wdata = $urandom;
      r_en  = 2'($urandom_range(3));
      for (int unsigned k = 0; k < N_RD; k++)
        raddr[k*ADDR_W +: ADDR_W] = ($urandom_range(2) == 0) ? waddr : 3'($urandom_range(N_ENT - 1));
      tick("rand");
    end

    idle_inputs();
    r_en = 2'b11; raddr = {3'd4, 3'd2};
    tick("burst");
    mid_reset();
    tick("after_arst");
    for (int unsigned a = 0; a < N_ENT; a++) begin
      r_en = 2'b11; raddr = {3'(a), 3'(a)};
      tick("arst_read");
      check("arst_entry", bus_n.r_data_o[31:0], RST_VAL);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
